// File: rtl/datamem_mmio_if.sv
// rtl/datamem_mmio_if.sv - load/store port and TX byte stream bundle for datamem_mmio
//
// Purpose: groups the core's data-side bus and the TX stream handshake so the
// memory subsystem and its driver share one connection.
// Signals:
//   data_addr  [31:0]  byte address from the core (bits [1:0] ignored)
//   datamem_wr [3:0]   per-byte write strobes, bit n writes lane n
//   data_out0..3 [7:0] store byte lanes 0..3
//   data_in    [31:0]  combinational read data back to the core
//   tx_data    [7:0]   FIFO head byte, 0 when empty
//   tx_valid           FIFO not empty
//   tx_ready           sink accepts the head byte
//   timer_irq          registered mtime >= mtimecmp
// Modports: master = core/sink side, slave = memory subsystem.

interface datamem_mmio_if;
  logic [31:0] data_addr;
  logic [3:0]  datamem_wr;
  logic [7:0]  data_out0;
  logic [7:0]  data_out1;
  logic [7:0]  data_out2;
  logic [7:0]  data_out3;
  logic [31:0] data_in;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        timer_irq;

  modport master (
    output data_addr, datamem_wr, data_out0, data_out1, data_out2, data_out3, tx_ready,
    input  data_in, tx_data, tx_valid, timer_irq
  );

  modport slave (
    input  data_addr, datamem_wr, data_out0, data_out1, data_out2, data_out3, tx_ready,
    output data_in, tx_data, tx_valid, timer_irq
  );
endinterface

// File: rtl/datamem_mmio.sv
// rtl/datamem_mmio.sv - data-side RAM, TX byte FIFO and optional machine timer
//
// Purpose: services the core's load/store port. Non-MMIO addresses hit a
// byte-writable word RAM; the MMIO window holds a TX FIFO that drains over a
// valid/ready byte stream plus, when DMEM_TIMER_EN is defined, a 64-bit
// mtime/mtimecmp pair driving timer_irq. Reads are combinational and have no
// side effects because the core presents data_addr every cycle with no strobe.
// Ports:
//   clk   single clock, rising edge
//   rstn  asynchronous active-low reset
//   bus   datamem_mmio_if.slave (load/store port, TX stream, timer_irq)
// Parameters: DEPTH_LOG2 (RAM words = 2^DEPTH_LOG2), FIFO_DEPTH (power of two,
//   2..16), MMIO_BASE (only bits [31:16] decoded).
// Build option: DMEM_TIMER_EN enables mtime/mtimecmp at offsets 0x08..0x14.

module datamem_mmio #(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h0001_0000
) (
  input  logic           clk,
  input  logic           rstn,
  datamem_mmio_if.slave  bus
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [7:0] OFF_TXDATA    = 8'h00;
  localparam logic [7:0] OFF_STATUS    = 8'h04;
`ifdef DMEM_TIMER_EN
  localparam logic [7:0] OFF_MTIME_LO  = 8'h08;
  localparam logic [7:0] OFF_MTIME_HI  = 8'h0C;
  localparam logic [7:0] OFF_MTCMP_LO  = 8'h10;
  localparam logic [7:0] OFF_MTCMP_HI  = 8'h14;
`endif

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic                  w_mmio_sel;
  logic [7:0]            w_off;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [31:0]           w_wdata;
  logic                  w_unused_addr;

  assign w_mmio_sel = (bus.data_addr[31:16] == MMIO_BASE[31:16]);
  assign w_off      = bus.data_addr[7:0];
  assign w_idx      = bus.data_addr[DEPTH_LOG2+1:2];
  assign w_wdata    = {bus.data_out3, bus.data_out2, bus.data_out1, bus.data_out0};
  // Low byte-offset bits and RAM alias bits are intentionally ignored.
  assign w_unused_addr = ^bus.data_addr;

  // ---------------------------------------------------------------------
  // Word RAM: no reset so contents survive rstn pulses.
  // ---------------------------------------------------------------------
  logic [31:0] r_mem [WORDS];

  always_ff @(posedge clk) begin
    if (!w_mmio_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.datamem_wr[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------
  logic [7:0]       r_buf [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push_req;
  logic w_push_ok;
  logic w_push_drop;
  logic w_ovf_clr;

  assign w_full      = (r_count == CNT_FULL);
  assign w_empty     = (r_count == '0);
  assign w_pop       = !w_empty && bus.tx_ready;
  assign w_push_req  = w_mmio_sel && (w_off == OFF_TXDATA) && bus.datamem_wr[0];
  // A pop in the same cycle frees the slot the push needs, so full only
  // drops the byte when nothing leaves.
  assign w_push_ok   = w_push_req && (!w_full || w_pop);
  assign w_push_drop = w_push_req && w_full && !w_pop;
  assign w_ovf_clr   = w_mmio_sel && (w_off == OFF_STATUS) && bus.datamem_wr[0]
                       && bus.data_out0[2];

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_buf[r_wr_ptr] <= bus.data_out0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (!w_push_ok && w_pop) begin
        r_count <= r_count - CNT_ONE;
      end
      if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end else if (w_push_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // tx_valid/tx_data are combinational from the count so an asynchronous
  // reset drops them immediately.
  assign bus.tx_valid = !w_empty;
  assign bus.tx_data  = w_empty ? 8'h00 : r_buf[r_rd_ptr];

  logic [4:0]  w_cnt5;
  logic [31:0] w_status;

  assign w_cnt5   = 5'(r_count);
  assign w_status = {23'd0, w_cnt5, 1'b0, r_ovf, w_empty, w_full};

  // ---------------------------------------------------------------------
  // Machine timer
  // ---------------------------------------------------------------------
`ifdef DMEM_TIMER_EN
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_irq;

  logic w_any_wr;
  logic w_mtime_lo_we;
  logic w_mtime_hi_we;
  logic w_mtcmp_lo_we;
  logic w_mtcmp_hi_we;

  assign w_any_wr      = w_mmio_sel && (|bus.datamem_wr);
  assign w_mtime_lo_we = w_any_wr && (w_off == OFF_MTIME_LO);
  assign w_mtime_hi_we = w_any_wr && (w_off == OFF_MTIME_HI);
  assign w_mtcmp_lo_we = w_any_wr && (w_off == OFF_MTCMP_LO);
  assign w_mtcmp_hi_we = w_any_wr && (w_off == OFF_MTCMP_HI);

  function automatic logic [31:0] f_merge(input logic [31:0] old_word,
                                          input logic [31:0] new_word,
                                          input logic [3:0]  be);
    f_merge = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        f_merge[8*i +: 8] = new_word[8*i +: 8];
      end
    end
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_irq      <= 1'b0;
    end else begin
      // Any mtime write freezes the whole counter for that cycle so software
      // sees exactly the value it wrote.
      if (w_mtime_lo_we || w_mtime_hi_we) begin
        if (w_mtime_lo_we) begin
          r_mtime[31:0] <= f_merge(r_mtime[31:0], w_wdata, bus.datamem_wr);
        end
        if (w_mtime_hi_we) begin
          r_mtime[63:32] <= f_merge(r_mtime[63:32], w_wdata, bus.datamem_wr);
        end
      end else begin
        r_mtime <= r_mtime + 64'd1;
      end
      if (w_mtcmp_lo_we) begin
        r_mtimecmp[31:0] <= f_merge(r_mtimecmp[31:0], w_wdata, bus.datamem_wr);
      end
      if (w_mtcmp_hi_we) begin
        r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], w_wdata, bus.datamem_wr);
      end
      r_irq <= (r_mtime >= r_mtimecmp);
    end
  end

  assign bus.timer_irq = r_irq;
`else
  assign bus.timer_irq = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Read mux: register state only, so reads never disturb anything.
  // ---------------------------------------------------------------------
  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    if (w_mmio_sel) begin
      case (w_off)
        OFF_STATUS:   w_rdata = w_status;
`ifdef DMEM_TIMER_EN
        OFF_MTIME_LO: w_rdata = r_mtime[31:0];
        OFF_MTIME_HI: w_rdata = r_mtime[63:32];
        OFF_MTCMP_LO: w_rdata = r_mtimecmp[31:0];
        OFF_MTCMP_HI: w_rdata = r_mtimecmp[63:32];
`endif
        default:      w_rdata = '0;
      endcase
    end else begin
      w_rdata = r_mem[w_idx];
    end
  end

  assign bus.data_in = w_rdata;

endmodule

// File: doc/datamem_mmio.md
# datamem_mmio

Data-side memory subsystem on the core's load/store port: consumes `data_addr`, `datamem_wr` and the four store byte lanes, and returns `data_in`. Contains a byte-writable word RAM, a transmit FIFO that drains to a byte stream over a valid/ready handshake, and an optional 64-bit machine timer with compare interrupt. Reads are combinational and side-effect free, because the core drives `data_addr` every cycle with no read strobe.

## Interface
- `DEPTH_LOG2`, 10: RAM depth is 2^DEPTH_LOG2 32-bit words.
- `FIFO_DEPTH`, 8: TX FIFO entries; must be a power of two, 2..16.
- `MMIO_BASE`, 32'h0001_0000: MMIO region base; only bits [31:16] are decoded.

- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `data_addr`  in  32  byte address from the core; bits [1:0] are ignored.
- `datamem_wr`  in  4  per-byte write strobes; bit n writes lane n.
- `data_out0`..`data_out3`  in  8 each  store byte lanes 0..3.
- `data_in`  out  32  read data to the core (combinational).
- `tx_data`  out  8  FIFO head byte; 0 when the FIFO is empty.
- `tx_valid`  out  1  FIFO not empty.
- `tx_ready`  in  1  sink accepts the byte.
- `timer_irq`  out  1  registered `mtime >= mtimecmp`.

## Operation
- **Address decode**
  - MMIO is selected when `data_addr[31:16] == MMIO_BASE[31:16]`.
  - Otherwise RAM is selected. The word index is `data_addr[DEPTH_LOG2+1:2]`; upper bits alias.
- **RAM**
  - Each lane with its strobe set is written at the clock edge.
  - Contents are not reset.
- **MMIO offsets (`data_addr[7:0]`)**
  - 0x00 TXDATA: a write with `datamem_wr[0]` set pushes `data_out0`. Reads return 0.
  - 0x04 STATUS (read): bit0 full, bit1 empty, bit2 overflow (sticky), bits[8:4] count. Writing lane0 with bit2 = 1 clears overflow.
  - 0x08/0x0C MTIME lo/hi, 0x10/0x14 MTIMECMP lo/hi. These are byte-writable per strobe.
  - Any other offset reads 0; writes to it are ignored.
- **FIFO**
  - Circular buffer with read/write pointers and a count of log2(FIFO_DEPTH)+1 bits.
  - Pop occurs when `tx_valid && tx_ready`.
  - Push while full without a simultaneous pop: the byte is dropped and overflow is set.
  - Push and pop in the same cycle while full: the push is accepted and count is unchanged.
  - Push and pop in the same cycle while not empty: count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **Timer**
  - `mtime` increments by 1 every cycle and wraps from 2^64-1 to 0.
  - A write to either MTIME word replaces the written bytes. The whole 64-bit counter does not increment in that cycle.
  - The compare is 64-bit unsigned.
- **Reset values:** `tx_valid` 0, `tx_data` 0, `timer_irq` 0, pointers/count 0, overflow 0, `mtime` 0, `mtimecmp` all ones.
- **Reset mid-operation:** the FIFO is flushed immediately (asynchronously) and `tx_valid` drops at once. RAM retains its contents.

## Timing
- `data_in` is a same-cycle combinational read.
- A read of an address being written in the same cycle returns the old value; the new value is visible from the next cycle.
- A push is visible on `tx_valid`/STATUS one cycle after the write edge.
- `tx_data` is stable while `tx_valid && !tx_ready`.
- `timer_irq` asserts one cycle after `mtime >= mtimecmp` becomes true. It deasserts one cycle after a `mtimecmp` write makes the compare false.
- STATUS and MTIME reads reflect register state at the start of the cycle.

## Configuration
- `DMEM_TIMER_EN` defined: the timer and compare logic are present as described.
- `DMEM_TIMER_EN` undefined: no timer registers exist; offsets 0x08–0x14 read 0 and writes are ignored; `timer_irq` is tied to 0.

## Test plan
- **RAM byte lanes:** write 0xDEADBEEF with strobe 4'b1111 to 0x40, then strobe 4'b0010 with lane1 = 0x12 -> read 0xDEAD12EF. A same-cycle read during the second write returns 0xDEADBEEF.
- **FIFO fill and overflow:** with `tx_ready` = 0, push 9 bytes 0x01..0x09 -> STATUS = count 8, full, overflow set. Raise `tx_ready` -> 0x01..0x08 stream out on consecutive cycles, then empty.
- **Simultaneous push/pop at full:** while full with `tx_ready` = 1, push 0xAA -> count stays 8, overflow not set, 0xAA emerges last.
- **Timer compare (with `DMEM_TIMER_EN`):** write MTIMECMP = 100, MTIME = 90 -> `timer_irq` rises exactly 11 cycles after the MTIME write edge. Writing MTIMECMP_HI = 1 clears it the next cycle.
- **Wrap and reset:** set MTIME = 0xFFFFFFFF_FFFFFFFE -> reads 0 two cycles later. Assert `rstn` low mid-stream -> `tx_valid` 0 immediately, STATUS empty after release, RAM data unchanged.
- **Macro off:** build without `DMEM_TIMER_EN` -> offsets 0x08–0x14 read 0 after writes, `timer_irq` stays 0.
